nw_traceback: RTL

Traceback stage of the Needleman-Wunsch array, directly downstream of the per-cell max/arrow unit. Once the score/direction matrix is filled, it walks the stored arrow codes from cell (len_a, len_b) back to (0,0). For each step it emits one alignment operation with its cell indices over a valid/ready stream. Ops are emitted in reverse order, end of alignment first.

---
 rtl/nw_traceback.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/nw_traceback.sv
// ---------------------------------------------------------------------------
// nw_traceback
//   Traceback walker for the Needleman-Wunsch array. Starting at cell
//   (len_a, len_b) it follows the stored arrow codes back to (0,0) and emits
//   one alignment op per visited cell, end of alignment first.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   start               begin a walk (accepted only in IDLE or ERR)
//   len_a, len_b        sequence lengths, sampled on an accepted start
//   dir_rd_en           direction-memory read strobe
//   dir_addr_i/j        read address (row/column), held until the next read
//   dir_data            arrow code, valid one cycle after dir_rd_en
//   out_valid/ready     op stream handshake
//   out_op              001 diag, 010 up, 100 left
//   out_i, out_j        cell that produced the op
//   step_cnt            ops accepted since the last start
//   busy                walk in progress
//   done                one-cycle pulse at walk completion
//   err                 error flag, held until reset or a new start
// ---------------------------------------------------------------------------
module nw_traceback #(
   parameter int MAX_LEN = 128,
   parameter int IDX_W   = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [IDX_W-1:0] len_a,
   input  logic [IDX_W-1:0] len_b,
   output logic             dir_rd_en,
   output logic [IDX_W-1:0] dir_addr_i,
   output logic [IDX_W-1:0] dir_addr_j,
   input  logic [2:0]       dir_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [2:0]       out_op,
   output logic [IDX_W-1:0] out_i,
   output logic [IDX_W-1:0] out_j,
   output logic [IDX_W:0]   step_cnt,
   output logic             busy,
   output logic             done,
   output logic             err
);

   localparam logic [2:0]     OP_DIAG   = 3'b001;
   localparam logic [2:0]     OP_UP     = 3'b010;
   localparam logic [2:0]     OP_LEFT   = 3'b100;
   localparam logic [IDX_W:0] MAX_LEN_W = (IDX_W+1)'(MAX_LEN);

   typedef enum logic [2:0] {
      S_IDLE, S_CHECK, S_READ, S_DECODE, S_EMIT, S_DONE, S_ERR
   } state_t;

   state_t           state_q, state_d;
   logic [IDX_W-1:0] i_q, j_q;
   logic [IDX_W-1:0] addr_i_q, addr_j_q;
   logic [2:0]       op_q;
   logic [IDX_W:0]   step_q;

   logic len_bad;
   logic start_ok;
   logic i_zero, j_zero;
   logic dir_onehot;
   logic move_uf;

   always_comb begin
      len_bad    = ({1'b0, len_a} > MAX_LEN_W) || ({1'b0, len_b} > MAX_LEN_W);
      start_ok   = start && !len_bad;
      i_zero     = (i_q == '0);
      j_zero     = (j_q == '0);
      dir_onehot = (dir_data == OP_DIAG) || (dir_data == OP_UP) ||
                   (dir_data == OP_LEFT);
      // Arrows are trusted for direction, but never for stepping past row/col 0.
      unique case (op_q)
         OP_DIAG: move_uf = i_zero || j_zero;
         OP_UP:   move_uf = i_zero;
         OP_LEFT: move_uf = j_zero;
         default: move_uf = 1'b1;
      endcase
   end

   // ---- state register ----
   always_ff @(posedge clk) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   // ---- next-state logic ----
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE, S_ERR: begin
            if (start) state_d = len_bad ? S_ERR : S_CHECK;
         end
         S_CHECK: begin
            if (i_zero && j_zero)      state_d = S_DONE;
            else if (i_zero || j_zero) state_d = S_EMIT;
            else                       state_d = S_READ;
         end
         S_READ:   state_d = S_DECODE;
         S_DECODE: state_d = dir_onehot ? S_EMIT : S_ERR;
         S_EMIT: begin
            if (out_ready) state_d = move_uf ? S_ERR : S_CHECK;
         end
         S_DONE:   state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   // ---- walk datapath: position, op, read address, step count ----
   always_ff @(posedge clk) begin
      if (rst) begin
         i_q      <= '0;
         j_q      <= '0;
         addr_i_q <= '0;
         addr_j_q <= '0;
         op_q     <= '0;
         step_q   <= '0;
      end else begin
         unique case (state_q)
            S_IDLE, S_ERR: begin
               if (start_ok) begin
                  i_q    <= len_a;
                  j_q    <= len_b;
                  step_q <= '0;
               end
            end
            S_CHECK: begin
               // Border cells have only one legal move, so no memory read.
               if (i_zero && !j_zero)      op_q <= OP_LEFT;
               else if (j_zero && !i_zero) op_q <= OP_UP;
               else if (!i_zero && !j_zero) begin
                  addr_i_q <= i_q;
                  addr_j_q <= j_q;
               end
            end
            S_DECODE: begin
               if (dir_onehot) op_q <= dir_data;
            end
            S_EMIT: begin
               if (out_ready && !move_uf) begin
                  if (op_q != OP_LEFT) i_q <= i_q - IDX_W'(1);
                  if (op_q != OP_UP)   j_q <= j_q - IDX_W'(1);
                  step_q <= step_q + (IDX_W+1)'(1);
               end
            end
            default: ;
         endcase
      end
   end

   // ---- output decode ----
   always_comb begin
      dir_rd_en = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b0;
      done      = 1'b0;
      err       = 1'b0;
      unique case (state_q)
         S_CHECK, S_DECODE: busy = 1'b1;
         S_READ: begin
            busy      = 1'b1;
            dir_rd_en = 1'b1;
         end
         S_EMIT: begin
            busy      = 1'b1;
            out_valid = 1'b1;
         end
         S_DONE:  done = 1'b1;
         S_ERR:   err  = 1'b1;
         default: ;
      endcase
   end

   assign dir_addr_i = addr_i_q;
   assign dir_addr_j = addr_j_q;
   assign out_op     = op_q;
   assign out_i      = i_q;
   assign out_j      = j_q;
   assign step_cnt   = step_q;

endmodule
